// File: rtl/wrp_shff_pkg.sv
// wrp_shff_pkg
//   Shared constants and types for the shuffle-wrapper AXI-stream sink FIFO.
//   Holds the default beat width, FIFO depth, threshold/slack values, the
//   derived level/pointer widths and the matching typedefs.
//   No ports: imported by the interface, the RAM and the top.
package wrp_shff_pkg;

  localparam int DATA_W_DEF            = 64;
  localparam int DEPTH_DEF             = 64;
  localparam int PROG_EMPTY_THRESH_DEF = 8;
  localparam int RDY_GAP_DEF           = 4;

  // Level needs one extra bit so that a completely full FIFO (DEPTH) is representable.
  localparam int LVL_W = $clog2(DEPTH_DEF) + 1;
  localparam int PTR_W = $clog2(DEPTH_DEF);

  typedef logic [LVL_W-1:0]      lvl_t;
  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  // Level width for an arbitrary depth, used where the depth is a parameter.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wrp_shff_axi_fifo_if.sv
// wrp_shff_axi_fifo_if
//   Bundles the AXI-stream sink handshake and the FWFT read port of the
//   shuffle-wrapper input FIFO.
//   Signals:
//     axi_vld / axi_rdy / axi_dat : upstream beat handshake and data
//     fifo_re                     : consumer pop request
//     fifo_rvld / fifo_rd         : head word valid and head word (FWFT)
//     fifo_ae                     : almost-empty flag
//     fifo_lvl                    : stored word count
//     err_udf                     : sticky underflow flag
//   Modports: slave = the FIFO, master = the upstream/consumer side.
interface wrp_shff_axi_fifo_if
  import wrp_shff_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);

  logic                         axi_vld;
  logic                         axi_rdy;
  logic [DATA_W-1:0]            axi_dat;
  logic                         fifo_re;
  logic                         fifo_rvld;
  logic [DATA_W-1:0]            fifo_rd;
  logic                         fifo_ae;
  logic [lvl_width(DEPTH)-1:0]  fifo_lvl;
  logic                         err_udf;

  modport slave (
    input  axi_vld, axi_dat, fifo_re,
    output axi_rdy, fifo_rvld, fifo_rd, fifo_ae, fifo_lvl, err_udf
  );

  modport master (
    output axi_vld, axi_dat, fifo_re,
    input  axi_rdy, fifo_rvld, fifo_rd, fifo_ae, fifo_lvl, err_udf
  );

endinterface

// File: rtl/wrp_shff_dram.sv
// wrp_shff_dram
//   1-write / 1-read distributed RAM, DEPTH x DATA_W. Synchronous write,
//   asynchronous read, no reset (contents are only meaningful behind the
//   FIFO pointers).
//   Ports:
//     clk    : write clock
//     we     : write enable
//     waddr  : write address
//     wdata  : write data
//     raddr  : read address
//     rdata  : read data, combinational from raddr
module wrp_shff_dram
  import wrp_shff_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wrp_shff_axi_fifo.sv
// wrp_shff_axi_fifo
//   AXI4-Stream sink for the shuffle wrapper. Beats accepted on
//   axi_vld & axi_rdy are captured into a one-word stage register, written
//   into a distributed-RAM FIFO on the following edge, and presented on a
//   first-word-fall-through read port popped by fifo_re.
//   axi_rdy is registered and throttled with RDY_GAP words of slack so the
//   FIFO can never overflow despite the one-cycle-late ready and the stage.
//   Ports:
//     clk     : single rising-edge clock
//     srst_n  : synchronous active-low reset
//     bus     : wrp_shff_axi_fifo_if.slave (handshake, read port, flags)
//   Optional feature macro: WRP_SHFF_AXI_FIFO_UDF_EN
//     defined     -> err_udf is a sticky flag set by fifo_re while empty
//     not defined -> err_udf is tied low
module wrp_shff_axi_fifo
  import wrp_shff_pkg::*;
#(
  parameter int DATA_W            = DATA_W_DEF,
  parameter int DEPTH             = DEPTH_DEF,
  parameter int PROG_EMPTY_THRESH = PROG_EMPTY_THRESH_DEF,
  parameter int RDY_GAP           = RDY_GAP_DEF
) (
  input  logic                clk,
  input  logic                srst_n,
  wrp_shff_axi_fifo_if.slave  bus
);

  localparam int LW = lvl_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] PTR_ONE   = 1;
  localparam logic [LW-1:0] LVL_ONE   = 1;
  localparam logic [LW-1:0] AE_LIMIT  = LW'(PROG_EMPTY_THRESH);
  // One bit wider than the level so level + staged beat cannot wrap.
  localparam logic [LW:0]   RDY_LIMIT = (LW+1)'(DEPTH - RDY_GAP);

  logic              s_vld;
  logic [DATA_W-1:0] s_dat;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     lvl;
  logic [LW-1:0]     lvl_nxt;
  logic [LW:0]       occ_nxt;
  logic              rdy_q;
  logic              accept;
  logic              pop;
  logic              rvld;
  logic [DATA_W-1:0] mem_rdata;

  assign accept = bus.axi_vld & rdy_q;
  assign rvld   = (lvl != '0);
  assign pop    = bus.fifo_re & rvld;

  // Next level: the staged beat always lands in memory on this edge, so a
  // write and a pop together leave the level unchanged.
  always_comb begin
    lvl_nxt = lvl;
    case ({s_vld, pop})
      2'b10:   lvl_nxt = lvl + LVL_ONE;
      2'b01:   lvl_nxt = lvl - LVL_ONE;
      default: lvl_nxt = lvl;
    endcase
  end

  // Occupancy the throttle has to protect: stored words plus whatever is
  // being captured into the stage on this edge.
  assign occ_nxt = {1'b0, lvl_nxt} + {{LW{1'b0}}, accept};

  // Stage register, pointers, level and the registered ready. The stage
  // empties every cycle, so s_vld simply follows the accept strobe.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      s_vld  <= 1'b0;
      s_dat  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      rdy_q  <= 1'b0;
    end else begin
      s_vld <= accept;
      if (accept) begin
        s_dat <= bus.axi_dat;
      end
      if (s_vld) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      lvl   <= lvl_nxt;
      rdy_q <= (occ_nxt < RDY_LIMIT);
    end
  end

  wrp_shff_dram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dram (
    .clk   (clk),
    .we    (s_vld & srst_n),
    .waddr (wr_ptr),
    .wdata (s_dat),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign bus.axi_rdy   = rdy_q;
  assign bus.fifo_rvld = rvld;
  assign bus.fifo_rd   = rvld ? mem_rdata : '0;
  assign bus.fifo_ae   = (lvl <= AE_LIMIT);
  assign bus.fifo_lvl  = lvl;

`ifdef WRP_SHFF_AXI_FIFO_UDF_EN
  logic udf_q;

  // Sticky: once a pop is requested against an empty FIFO the flag stays up
  // until the next reset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      udf_q <= 1'b0;
    end else if (bus.fifo_re && !rvld) begin
      udf_q <= 1'b1;
    end
  end

  assign bus.err_udf = udf_q;
`else
  assign bus.err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_wrp_shff_axi_fifo.sv
// tb_wrp_shff_axi_fifo
//   Directed bench for wrp_shff_axi_fifo: reset values, single-beat latency,
//   fill/throttle, sustained streaming, almost-empty threshold, random
//   handshake gaps, underflow flag and reset discarding stored data.
//   Popped words are checked against a queue of accepted beats.
module tb_wrp_shff_axi_fifo;
  import wrp_shff_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

`ifdef WRP_SHFF_AXI_FIFO_UDF_EN
  localparam logic EXP_UDF = 1'b1;
`else
  localparam logic EXP_UDF = 1'b0;
`endif

  logic  clk;
  logic  srst_n;
  int    total;
  int    bad;
  int    pops;
  word_t sb[$];

  wrp_shff_axi_fifo_if bus ();

  wrp_shff_axi_fifo dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, note the pre-edge outputs, step past the edge
  // and update the queue of accepted beats / check popped words.
  task automatic applyStimulus(input logic vld, input word_t dat, input logic re, output logic acc);
    logic  pre_rdy;
    logic  pre_rvld;
    logic  pre_rst_n;
    word_t pre_rd;
    word_t exp;
    bus.axi_vld = vld;
    bus.axi_dat = vld ? dat : 64'hBADD_F00D_BADD_F00D;
    bus.fifo_re = re;
    pre_rdy   = bus.axi_rdy;
    pre_rvld  = bus.fifo_rvld;
    pre_rd    = bus.fifo_rd;
    pre_rst_n = srst_n;
    @(posedge clk);
    #1;
    acc = vld && pre_rdy && pre_rst_n;
    if (acc) sb.push_back(dat);
    if (re && pre_rvld && pre_rst_n) begin
      pops++;
      if (sb.size() == 0) begin
        checkOutput("pop_unexpected_word", pre_rd, 64'h0);
      end else begin
        exp = sb.pop_front();
        checkOutput("pop_data", pre_rd, exp);
      end
    end
  endtask

  initial begin
    logic  a;
    int    sent;
    int    maxlvl;
    int    bubbles;
    int    p0;
    word_t d;

    total = 0;
    bad   = 0;
    pops  = 0;
    srst_n      = 1'b0;
    bus.axi_vld = 1'b0;
    bus.axi_dat = '0;
    bus.fifo_re = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_axi_rdy",   bus.axi_rdy,   0);
    checkOutput("rst_fifo_rvld", bus.fifo_rvld, 0);
    checkOutput("rst_fifo_lvl",  bus.fifo_lvl,  0);
    checkOutput("rst_fifo_rd",   bus.fifo_rd,   0);
    checkOutput("rst_fifo_ae",   bus.fifo_ae,   1);
    checkOutput("rst_err_udf",   bus.err_udf,   0);
    srst_n = 1'b1;
    checkOutput("rel_rdy_before_edge", bus.axi_rdy, 0);
    applyStimulus(0, 0, 0, a);
    checkOutput("rel_rdy_after_edge", bus.axi_rdy, 1);

    // Single beat: staged after the accept edge, visible after the next one
    applyStimulus(1, 64'hDEAD_BEEF_0000_0001, 0, a);
    checkOutput("single_accepted", a, 1);
    checkOutput("single_rvld_staged", bus.fifo_rvld, 0);
    checkOutput("single_lvl_staged",  bus.fifo_lvl,  0);
    applyStimulus(0, 0, 0, a);
    checkOutput("single_rvld", bus.fifo_rvld, 1);
    checkOutput("single_rd",   bus.fifo_rd,   64'hDEAD_BEEF_0000_0001);
    checkOutput("single_lvl",  bus.fifo_lvl,  1);
    applyStimulus(0, 0, 1, a);
    checkOutput("single_pop_rvld", bus.fifo_rvld, 0);
    checkOutput("single_pop_lvl",  bus.fifo_lvl,  0);
    checkOutput("single_pop_rd",   bus.fifo_rd,   0);

    // Fill without popping: ready closes once 60 beats are in flight
    sent   = 0;
    maxlvl = 0;
    for (int c = 0; c < 80; c++) begin
      applyStimulus(1, word_t'(sent), 0, a);
      if (a) sent++;
      if (int'(bus.fifo_lvl) > maxlvl) maxlvl = int'(bus.fifo_lvl);
    end
    checkOutput("fill_accepted", sent, 60);
    checkOutput("fill_lvl",      bus.fifo_lvl, 60);
    checkOutput("fill_max_lvl",  maxlvl, 60);
    checkOutput("fill_rdy_low",  bus.axi_rdy, 0);
    for (int i = 0; i < 60; i++) applyStimulus(0, 0, 1, a);
    checkOutput("drain_rvld",  bus.fifo_rvld, 0);
    checkOutput("drain_lvl",   bus.fifo_lvl,  0);
    checkOutput("drain_sb",    sb.size(),     0);
    checkOutput("drain_rdy",   bus.axi_rdy,   1);

    // Sustained streaming, one beat in and one word out per cycle
    sent    = 0;
    bubbles = 0;
    p0      = pops;
    for (int c = 0; c < 1400; c++) begin
      if (sent >= 1000 && sb.size() == 0) break;
      applyStimulus(sent < 1000, 64'h5000_0000_0000_0000 + word_t'(sent), 1, a);
      if (a) sent++;
      if (c >= 4 && c <= 990) begin
        if (!bus.axi_rdy || !bus.fifo_rvld || bus.fifo_lvl != 1) bubbles++;
      end
    end
    checkOutput("stream_sent",    sent, 1000);
    checkOutput("stream_popped",  pops - p0, 1000);
    checkOutput("stream_bubbles", bubbles, 0);
    checkOutput("stream_end_lvl", bus.fifo_lvl, 0);

    // Almost-empty threshold at level 8 / 9
    sent = 0;
    for (int c = 0; c < 20 && sent < 8; c++) begin
      applyStimulus(1, 64'hAE00_0000_0000_0000 + word_t'(sent), 0, a);
      if (a) sent++;
    end
    repeat (2) applyStimulus(0, 0, 0, a);
    checkOutput("ae_lvl8",   bus.fifo_lvl, 8);
    checkOutput("ae_at_8",   bus.fifo_ae,  1);
    applyStimulus(1, 64'hAE00_0000_0000_0008, 0, a);
    checkOutput("ae_9th_accepted", a, 1);
    repeat (2) applyStimulus(0, 0, 0, a);
    checkOutput("ae_lvl9",   bus.fifo_lvl, 9);
    checkOutput("ae_at_9",   bus.fifo_ae,  0);

    // Random valid / pop gaps, order checked through the queue
    for (int c = 0; c < 400; c++) begin
      d = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), a);
    end
    for (int c = 0; c < 200; c++) begin
      if (sb.size() == 0 && !bus.fifo_rvld) break;
      applyStimulus(0, 0, 1, a);
    end
    checkOutput("rand_sb_empty", sb.size(), 0);
    checkOutput("rand_lvl",      bus.fifo_lvl, 0);

    // Underflow flag
    applyStimulus(0, 0, 1, a);
    checkOutput("udf_set",  bus.err_udf,  EXP_UDF);
    checkOutput("udf_lvl",  bus.fifo_lvl, 0);
    checkOutput("udf_rvld", bus.fifo_rvld, 0);
    applyStimulus(0, 0, 0, a);
    checkOutput("udf_sticky", bus.err_udf, EXP_UDF);

    // Reset with 20 words stored and a beat being accepted
    sent = 0;
    for (int c = 0; c < 40 && sent < 20; c++) begin
      applyStimulus(1, 64'hC0DE_0000_0000_0000 + word_t'(sent), 0, a);
      if (a) sent++;
    end
    repeat (2) applyStimulus(0, 0, 0, a);
    checkOutput("pre_rst_lvl", bus.fifo_lvl, 20);
    srst_n = 1'b0;
    applyStimulus(1, 64'h1111_2222_3333_4444, 0, a);
    sb.delete();
    checkOutput("mid_rst_rdy",  bus.axi_rdy,   0);
    checkOutput("mid_rst_rvld", bus.fifo_rvld, 0);
    checkOutput("mid_rst_lvl",  bus.fifo_lvl,  0);
    checkOutput("mid_rst_rd",   bus.fifo_rd,   0);
    checkOutput("mid_rst_ae",   bus.fifo_ae,   1);
    checkOutput("mid_rst_udf",  bus.err_udf,   0);
    srst_n = 1'b1;
    repeat (4) applyStimulus(0, 0, 1, a);
    checkOutput("post_rst_rvld", bus.fifo_rvld, 0);
    checkOutput("post_rst_lvl",  bus.fifo_lvl,  0);
    checkOutput("post_rst_rdy",  bus.axi_rdy,   1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
